// File: rtl/rf_cmd_master.sv
// Byte-serial command master: parses write/read frames from UART RX, drives the
// register file port, and returns read data (or an error byte on timeout) to UART TX.
module rf_cmd_master #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 15,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE   = 8'hEE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_Busy,
    output logic                  Ctrl_Busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(RD_TIMEOUT);

    state_t                state_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic                  tx_vld_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [7:0]            timeout_cnt_q;
    logic [7:0]            timeout_cnt_d;

    assign timeout_cnt_d = timeout_cnt_q + 8'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            tx_vld_q      <= 1'b0;
            busy_q        <= 1'b0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            tx_data_q     <= '0;
            timeout_cnt_q <= '0;
        end else begin
            // Strobes are single-cycle: cleared every edge unless re-asserted below.
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (RX_D_VLD && RX_P_DATA == WR_CMD) begin
                        state_q <= WR_ADDR;
                        busy_q  <= 1'b1;
                    end else if (RX_D_VLD && RX_P_DATA == RD_CMD) begin
                        state_q <= RD_ADDR;
                        busy_q  <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        wr_data_q <= RX_P_DATA;
                        wr_en_q   <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q        <= RX_P_DATA[ADDR_WIDTH-1:0];
                        rd_en_q       <= 1'b1;
                        timeout_cnt_q <= '0;
                        state_q       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // A response arriving on the final wait cycle still beats the timeout.
                    if (RdData_Valid) begin
                        tx_data_q <= RdData;
                        state_q   <= TX_SEND;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_d;
                        if (timeout_cnt_d == TIMEOUT_LAST) begin
                            tx_data_q <= ERR_BYTE;
                            state_q   <= TX_SEND;
                        end
                    end
                end
                TX_SEND: begin
                    if (!TX_Busy) begin
                        tx_vld_q <= 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign Ctrl_Busy = busy_q;

endmodule
